// File: rtl/sd_pkg.sv
// Shared types and constants for the SD card SPI-mode init/read sequencer.
package sd_pkg;

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_GAP,
        ST_CMD0,
        ST_CMD8,
        ST_CMD55,
        ST_ACMD41,
        ST_CMD17,
        ST_READY,
        ST_ERROR
    } sd_init_state_t;

    typedef enum logic [3:0] {
        ERR_NONE     = 4'd0,
        ERR_CMD0     = 4'd1,
        ERR_CMD8     = 4'd2,
        ERR_ACMD41   = 4'd3,
        ERR_CMD17    = 4'd4,
        ERR_WATCHDOG = 4'd5
    } sd_err_t;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;

    localparam logic [7:0] CRC_CMD0 = 8'h95;
    localparam logic [7:0] CRC_CMD8 = 8'h87;
    localparam logic [7:0] CRC_NONE = 8'hFF;

    localparam logic [31:0] ARG_ZERO   = 32'h0000_0000;
    localparam logic [31:0] ARG_CMD8   = 32'h0000_01AA;
    localparam logic [31:0] ARG_ACMD41 = 32'h4000_0000;

    localparam logic [7:0] R1_IDLE  = 8'h01;
    localparam logic [7:0] R1_READY = 8'h00;

    typedef struct packed {
        logic [7:0]  number;
        logic [31:0] args;
        logic [7:0]  crc;
    } sd_cmd_t;

    // The command byte on the wire carries the start/transmission bits 01 above the index.
    function automatic sd_cmd_t make_cmd(input logic [5:0] idx, input logic [31:0] args,
                                         input logic [7:0] crc);
        sd_cmd_t c;
        c.number = {2'b01, idx};
        c.args   = args;
        c.crc    = crc;
        return c;
    endfunction

endpackage

// File: rtl/sd_cycle_timer.sv
// Clearable up-counter with terminal-count flag; reused for power-up delay and command watchdog.
module sd_cycle_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc_o = (count_q == limit_i);

endmodule

// File: rtl/sd_init_seq.sv
// SD SPI-mode init (CMD0/CMD8/CMD55+ACMD41) and CMD17 read sequencer in front of sd_cmd.
// Optional per-command timeout enabled by defining SD_WATCHDOG_EN.
module sd_init_seq
    import sd_pkg::*;
#(
    parameter int POWERUP_CYCLES  = 1000,
    parameter int ACMD41_RETRIES  = 255,
    parameter int WATCHDOG_CYCLES = 4095
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        init_req,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        ready,
    output logic        busy,
    output logic        error,
    output logic [3:0]  err_code,
    output logic [7:0]  cmd_number,
    output logic [31:0] cmd_args,
    output logic [7:0]  cmd_crc,
    output logic        cmd_start,
    input  logic        cmd_done,
    input  logic [7:0]  resp_flags,
    input  logic [31:0] data_in
);

    localparam int TW = 16;

    sd_init_state_t state_q, state_d, pend_q, pend_d;
    logic [7:0]     cmd_number_q, cmd_number_d;
    logic [31:0]    cmd_args_q, cmd_args_d;
    logic [7:0]     cmd_crc_q, cmd_crc_d;
    logic           cmd_start_q, cmd_start_d;
    logic           rd_valid_q, rd_valid_d;
    logic [31:0]    rd_data_q, rd_data_d;
    sd_err_t        err_q, err_d;
    logic [7:0]     retry_q, retry_d;
    logic [7:0]     retry_inc;

    logic           issue;
    sd_cmd_t        issue_cmd;
    sd_init_state_t issue_state;
    logic           fail;
    sd_err_t        fail_code;

    logic           tmr_clear, tmr_en, tmr_tc, wdog_expired;
    logic [TW-1:0]  tmr_limit;

    assign retry_inc = retry_q + 8'd1;
    assign tmr_limit = (state_q == ST_PWRUP) ? TW'(POWERUP_CYCLES - 1) : TW'(WATCHDOG_CYCLES - 1);

`ifdef SD_WATCHDOG_EN
    assign tmr_en       = (state_q == ST_PWRUP) || cmd_start_q;
    assign wdog_expired = cmd_start_q && tmr_tc && !cmd_done;
`else
    assign tmr_en       = (state_q == ST_PWRUP);
    assign wdog_expired = 1'b0;
`endif

    sd_cycle_timer #(.WIDTH(TW)) u_timer (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .clear_i (tmr_clear),
        .en_i    (tmr_en),
        .limit_i (tmr_limit),
        .tc_o    (tmr_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_PWRUP;
            pend_q       <= ST_CMD0;
            cmd_number_q <= 8'h40;
            cmd_args_q   <= '0;
            cmd_crc_q    <= CRC_CMD0;
            cmd_start_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            err_q        <= ERR_NONE;
            retry_q      <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            cmd_number_q <= cmd_number_d;
            cmd_args_q   <= cmd_args_d;
            cmd_crc_q    <= cmd_crc_d;
            cmd_start_q  <= cmd_start_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            err_q        <= err_d;
            retry_q      <= retry_d;
        end
    end

    // Every command passes through GAP: its fields are registered on entry and
    // cmd_start rises on leaving, giving exactly one low cycle between commands.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        cmd_number_d = cmd_number_q;
        cmd_args_d   = cmd_args_q;
        cmd_crc_d    = cmd_crc_q;
        cmd_start_d  = cmd_start_q;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        err_d        = err_q;
        retry_d      = retry_q;
        tmr_clear    = 1'b0;
        issue        = 1'b0;
        issue_cmd    = make_cmd(CMD0, ARG_ZERO, CRC_CMD0);
        issue_state  = ST_CMD0;
        fail         = 1'b0;
        fail_code    = ERR_NONE;

        case (state_q)
            ST_PWRUP: begin
                if (tmr_tc) begin
                    issue = 1'b1;
                end
            end
            ST_GAP: begin
                tmr_clear   = 1'b1;
                cmd_start_d = 1'b1;
                state_d     = pend_q;
            end
            ST_READY, ST_ERROR: begin
                if (init_req) begin
                    state_d   = ST_PWRUP;
                    err_d     = ERR_NONE;
                    retry_d   = '0;
                    tmr_clear = 1'b1;
                end else if (rd_req && state_q == ST_READY) begin
                    issue       = 1'b1;
                    issue_cmd   = make_cmd(CMD17, rd_addr, CRC_NONE);
                    issue_state = ST_CMD17;
                end
            end
            default: begin
                if (cmd_done) begin
                    cmd_start_d = 1'b0;
                    case (state_q)
                        ST_CMD0: begin
                            if (resp_flags == R1_IDLE) begin
                                issue       = 1'b1;
                                issue_cmd   = make_cmd(CMD8, ARG_CMD8, CRC_CMD8);
                                issue_state = ST_CMD8;
                            end else begin
                                fail      = 1'b1;
                                fail_code = ERR_CMD0;
                            end
                        end
                        ST_CMD8: begin
                            if (resp_flags == R1_IDLE) begin
                                issue       = 1'b1;
                                issue_cmd   = make_cmd(CMD55, ARG_ZERO, CRC_NONE);
                                issue_state = ST_CMD55;
                            end else begin
                                fail      = 1'b1;
                                fail_code = ERR_CMD8;
                            end
                        end
                        ST_CMD55: begin
                            if (resp_flags == R1_IDLE || resp_flags == R1_READY) begin
                                issue       = 1'b1;
                                issue_cmd   = make_cmd(ACMD41, ARG_ACMD41, CRC_NONE);
                                issue_state = ST_ACMD41;
                            end else begin
                                fail      = 1'b1;
                                fail_code = ERR_ACMD41;
                            end
                        end
                        ST_ACMD41: begin
                            if (resp_flags == R1_READY) begin
                                state_d = ST_READY;
                            end else if (resp_flags == R1_IDLE) begin
                                retry_d = retry_inc;
                                if (retry_inc == 8'(ACMD41_RETRIES)) begin
                                    fail      = 1'b1;
                                    fail_code = ERR_ACMD41;
                                end else begin
                                    issue       = 1'b1;
                                    issue_cmd   = make_cmd(CMD55, ARG_ZERO, CRC_NONE);
                                    issue_state = ST_CMD55;
                                end
                            end else begin
                                fail      = 1'b1;
                                fail_code = ERR_ACMD41;
                            end
                        end
                        ST_CMD17: begin
                            if (resp_flags == R1_READY) begin
                                rd_data_d  = data_in;
                                rd_valid_d = 1'b1;
                                state_d    = ST_READY;
                            end else begin
                                fail      = 1'b1;
                                fail_code = ERR_CMD17;
                            end
                        end
                        default: begin
                            state_d = state_q;
                        end
                    endcase
                end else if (wdog_expired) begin
                    cmd_start_d = 1'b0;
                    fail        = 1'b1;
                    fail_code   = ERR_WATCHDOG;
                end
            end
        endcase

        if (issue) begin
            cmd_number_d = issue_cmd.number;
            cmd_args_d   = issue_cmd.args;
            cmd_crc_d    = issue_cmd.crc;
            state_d      = ST_GAP;
            pend_d       = issue_state;
        end
        if (fail) begin
            state_d = ST_ERROR;
            err_d   = fail_code;
        end
    end

    assign cmd_number = cmd_number_q;
    assign cmd_args   = cmd_args_q;
    assign cmd_crc    = cmd_crc_q;
    assign cmd_start  = cmd_start_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign err_code   = err_q;
    assign ready      = (state_q == ST_READY);
    assign error      = (state_q == ST_ERROR);
    assign busy       = (state_q != ST_READY) && (state_q != ST_ERROR);

endmodule

// File: tb/tb_sd_init_seq.sv
// Directed self-checking bench for sd_init_seq with a hand-driven card/sd_cmd responder.
// Exercises the command timeout path when SD_WATCHDOG_EN is defined.
module tb_sd_init_seq;

    localparam int PWR = 10;
    localparam int RET = 4;
    localparam int WD  = 40;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        init_req = 1'b0;
    logic        rd_req = 1'b0;
    logic [31:0] rd_addr = '0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        ready, busy, error;
    logic [3:0]  err_code;
    logic [7:0]  cmd_number;
    logic [31:0] cmd_args;
    logic [7:0]  cmd_crc;
    logic        cmd_start;
    logic        cmd_done = 1'b0;
    logic [7:0]  resp_flags = '0;
    logic [31:0] data_in = '0;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    sd_init_seq #(
        .POWERUP_CYCLES (PWR),
        .ACMD41_RETRIES (RET),
        .WATCHDOG_CYCLES(WD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .init_req  (init_req),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .ready     (ready),
        .busy      (busy),
        .error     (error),
        .err_code  (err_code),
        .cmd_number(cmd_number),
        .cmd_args  (cmd_args),
        .cmd_crc   (cmd_crc),
        .cmd_start (cmd_start),
        .cmd_done  (cmd_done),
        .resp_flags(resp_flags),
        .data_in   (data_in)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One-cycle request pulse, driven at a falling edge.
    task automatic applyStimulus(input logic initReq, input logic rdReq, input logic [31:0] addr);
        init_req = initReq;
        rd_req   = rdReq;
        rd_addr  = addr;
        @(negedge clk);
        init_req = 1'b0;
        rd_req   = 1'b0;
    endtask

    task automatic waitStart(output int lowCycles);
        lowCycles = 0;
        while (cmd_start !== 1'b1 && lowCycles < 400) begin
            @(negedge clk);
            lowCycles++;
        end
        if (cmd_start !== 1'b1) checkOutput("start timeout", 32'(cmd_start), 32'd1);
    endtask

    task automatic serveCmd(input string tag, input logic [7:0] expNum, input logic [31:0] expArg,
                            input logic [7:0] expCrc, input int expLow,
                            input logic [7:0] resp, input logic [31:0] data);
        int low;
        waitStart(low);
        if (expLow >= 0) checkOutput({tag, " low cycles"}, 32'(low), 32'(expLow));
        checkOutput({tag, " number"}, 32'(cmd_number), 32'(expNum));
        checkOutput({tag, " args"}, cmd_args, expArg);
        checkOutput({tag, " crc"}, 32'(cmd_crc), 32'(expCrc));
        @(negedge clk);
        checkOutput({tag, " start held"}, 32'(cmd_start), 32'd1);
        checkOutput({tag, " number held"}, 32'(cmd_number), 32'(expNum));
        cmd_done   = 1'b1;
        resp_flags = resp;
        data_in    = data;
        @(negedge clk);
        cmd_done   = 1'b0;
        data_in    = '0;
        checkOutput({tag, " start fall"}, 32'(cmd_start), 32'd0);
    endtask

    task automatic runInit(input int nRetry);
        serveCmd("CMD0", 8'h40, 32'h0, 8'h95, PWR + 1, 8'h01, 32'h0);
        serveCmd("CMD8", 8'h48, 32'h1AA, 8'h87, 1, 8'h01, 32'h0);
        for (int i = 0; i < nRetry; i++) begin
            serveCmd("CMD55", 8'h77, 32'h0, 8'hFF, 1, 8'h01, 32'h0);
            serveCmd("ACMD41", 8'h69, 32'h4000_0000, 8'hFF, 1, 8'h01, 32'h0);
        end
        serveCmd("CMD55", 8'h77, 32'h0, 8'hFF, 1, 8'h01, 32'h0);
        serveCmd("ACMD41", 8'h69, 32'h4000_0000, 8'hFF, 1, 8'h00, 32'h0);
        checkOutput("init ready", 32'(ready), 32'd1);
        checkOutput("init busy", 32'(busy), 32'd0);
        checkOutput("init err_code", 32'(err_code), 32'd0);
    endtask

    task automatic expectNoStart(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (cmd_start === 1'b1) seen = 1'b1;
        end
        checkOutput(tag, 32'(seen), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " cmd_start"}, 32'(cmd_start), 32'd0);
        checkOutput({tag, " cmd_number"}, 32'(cmd_number), 32'h40);
        checkOutput({tag, " cmd_args"}, cmd_args, 32'h0);
        checkOutput({tag, " cmd_crc"}, 32'(cmd_crc), 32'h95);
        checkOutput({tag, " rd_valid"}, 32'(rd_valid), 32'd0);
        checkOutput({tag, " rd_data"}, rd_data, 32'h0);
        checkOutput({tag, " ready"}, 32'(ready), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd1);
        checkOutput({tag, " error"}, 32'(error), 32'd0);
        checkOutput({tag, " err_code"}, 32'(err_code), 32'd0);
    endtask

    initial begin
        int low;

        @(negedge clk);
        checkResetValues("reset");
        reset_n = 1'b1;

        // Card needs three ACMD41 retries before leaving idle.
        runInit(3);

        applyStimulus(1'b0, 1'b1, 32'h0000_0200);
        serveCmd("CMD17", 8'h51, 32'h0000_0200, 8'hFF, 1, 8'h00, 32'hDEAD_BEEF);
        checkOutput("read rd_valid", 32'(rd_valid), 32'd1);
        checkOutput("read rd_data", rd_data, 32'hDEAD_BEEF);
        checkOutput("read ready", 32'(ready), 32'd1);
        @(negedge clk);
        checkOutput("read rd_valid pulse", 32'(rd_valid), 32'd0);

        applyStimulus(1'b0, 1'b1, 32'h0000_0400);
        serveCmd("CMD17 bad", 8'h51, 32'h0000_0400, 8'hFF, 1, 8'h04, 32'h1234_5678);
        checkOutput("cmd17 err error", 32'(error), 32'd1);
        checkOutput("cmd17 err code", 32'(err_code), 32'd4);
        checkOutput("cmd17 err rd_data", rd_data, 32'hDEAD_BEEF);
        checkOutput("cmd17 err rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("cmd17 err busy", 32'(busy), 32'd0);

        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("reinit busy", 32'(busy), 32'd1);
        checkOutput("reinit error", 32'(error), 32'd0);
        checkOutput("reinit err_code", 32'(err_code), 32'd0);
        serveCmd("CMD0 bad", 8'h40, 32'h0, 8'h95, PWR + 1, 8'hFF, 32'h0);
        checkOutput("cmd0 err error", 32'(error), 32'd1);
        checkOutput("cmd0 err code", 32'(err_code), 32'd1);
        expectNoStart("cmd0 err no command", 30);

        // ACMD41 never leaves idle: error after exactly RET ACMD41 commands.
        applyStimulus(1'b1, 1'b0, 32'h0);
        serveCmd("CMD0", 8'h40, 32'h0, 8'h95, PWR + 1, 8'h01, 32'h0);
        serveCmd("CMD8", 8'h48, 32'h1AA, 8'h87, 1, 8'h01, 32'h0);
        for (int i = 0; i < RET; i++) begin
            serveCmd("CMD55 loop", 8'h77, 32'h0, 8'hFF, 1, 8'h01, 32'h0);
            checkOutput("retry loop error", 32'(error), 32'd0);
            serveCmd("ACMD41 loop", 8'h69, 32'h4000_0000, 8'hFF, 1, 8'h01, 32'h0);
        end
        checkOutput("retries error", 32'(error), 32'd1);
        checkOutput("retries err_code", 32'(err_code), 32'd3);
        expectNoStart("retries no command", 30);

        applyStimulus(1'b1, 1'b0, 32'h0);
        runInit(0);

        // init_req beats a simultaneous rd_req: next command must be CMD0.
        applyStimulus(1'b1, 1'b1, 32'h0000_0800);
        checkOutput("init+rd busy", 32'(busy), 32'd1);
        checkOutput("init+rd ready", 32'(ready), 32'd0);
        runInit(0);

        applyStimulus(1'b0, 1'b1, 32'h0000_1000);
        waitStart(low);
        checkOutput("pre-reset cmd_number", 32'(cmd_number), 32'h51);
        #2 reset_n = 1'b0;
        #1 checkResetValues("async reset");
        @(negedge clk);
        reset_n = 1'b1;
        runInit(0);

        applyStimulus(1'b0, 1'b1, 32'h0000_2000);
        waitStart(low);
`ifdef SD_WATCHDOG_EN
        repeat (WD - 1) @(negedge clk);
        checkOutput("watchdog early error", 32'(error), 32'd0);
        checkOutput("watchdog early start", 32'(cmd_start), 32'd1);
        @(negedge clk);
        checkOutput("watchdog error", 32'(error), 32'd1);
        checkOutput("watchdog err_code", 32'(err_code), 32'd5);
        checkOutput("watchdog start", 32'(cmd_start), 32'd0);
`else
        repeat (WD + 20) @(negedge clk);
        checkOutput("no watchdog error", 32'(error), 32'd0);
        checkOutput("no watchdog busy", 32'(busy), 32'd1);
        checkOutput("no watchdog start", 32'(cmd_start), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
